// File: rtl/ascon_pack.sv
// Shared types and helpers for the two-requester ASCON core arbiter.
package ascon_pack;

  localparam int NB_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Round-robin pick: a lone request wins, a tie goes to whoever did not own last.
  function automatic logic rr_pick(input logic [NB_REQ-1:0] req, input logic last_owner);
    if (req[0] && req[1]) return ~last_owner;
    return req[1];
  endfunction

  function automatic logic [NB_REQ-1:0] owner_mask(input logic owner);
    return {owner, ~owner};
  endfunction

endpackage

// File: rtl/cpt_timeout.sv
// BUSY-cycle counter: cleared by init, advanced by enable, wrap flags the last allowed cycle.
module cpt_timeout #(
  parameter int MAX = 511
) (
  input  logic clock_i,
  input  logic resetb_i,
  input  logic init_i,
  input  logic en_i,
  output logic wrap_o
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      cnt <= '0;
    end else if (init_i) begin
      cnt <= '0;
    end else if (en_i) begin
      cnt <= cnt + W'(1);
    end
  end

  // High during the MAX-th enabled cycle, so the owner sees the abort one edge later.
  assign wrap_o = en_i && (cnt == W'(MAX - 1));

endmodule

// File: rtl/ascon_arbiter.sv
// Shares one ASCON core between two requesters with round-robin ownership and a job timeout.
module ascon_arbiter
  import ascon_pack::*;
#(
  parameter int TIMEOUT_CYC = 511
) (
  input  logic              clock_i,
  input  logic              resetb_i,
  input  logic [NB_REQ-1:0] req_i,
  input  logic [127:0]      key0_i,
  input  logic [127:0]      key1_i,
  input  logic [127:0]      nonce0_i,
  input  logic [127:0]      nonce1_i,
  input  logic [63:0]       data0_i,
  input  logic [63:0]       data1_i,
  input  logic [NB_REQ-1:0] data_valid_i,
  output logic [NB_REQ-1:0] grant_o,
  output logic [NB_REQ-1:0] cipher_valid_o,
  output logic [63:0]       cipher_o,
  output logic [NB_REQ-1:0] end_o,
  output logic [NB_REQ-1:0] err_o,
  output logic [127:0]      tag_o,
  output logic              core_start_o,
  output logic              core_data_valid_o,
  output logic [63:0]       core_data_o,
  output logic [127:0]      core_key_o,
  output logic [127:0]      core_nonce_o,
  input  logic              core_cipher_valid_i,
  input  logic              core_end_i,
  input  logic [63:0]       core_cipher_i,
  input  logic [127:0]      core_tag_i,
  output arb_state_t        state_o
);

  arb_state_t state;
  logic       owner;
  logic       last_owner;
  logic       next_owner;
  logic       busy;
  logic       tmo_wrap;

  assign next_owner = rr_pick(req_i, last_owner);
  assign busy       = (state == BUSY);
  assign state_o    = state;

  cpt_timeout #(.MAX(TIMEOUT_CYC)) u_cpt_timeout (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .init_i   (state == START),
    .en_i     (busy),
    .wrap_o   (tmo_wrap)
  );

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_owner   <= 1'b1;
      grant_o      <= '0;
      core_start_o <= 1'b0;
      end_o        <= '0;
      err_o        <= '0;
      tag_o        <= '0;
      core_key_o   <= '0;
      core_nonce_o <= '0;
    end else begin
      end_o        <= '0;
      err_o        <= '0;
      core_start_o <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_i) begin
            owner        <= next_owner;
            core_key_o   <= next_owner ? key1_i : key0_i;
            core_nonce_o <= next_owner ? nonce1_i : nonce0_i;
            grant_o      <= owner_mask(next_owner);
            core_start_o <= 1'b1;
            state        <= START;
          end
        end
        START: state <= BUSY;
        BUSY: begin
          // Completion takes priority over a timeout landing on the same cycle.
          if (core_end_i) begin
            tag_o   <= core_tag_i;
            end_o   <= owner_mask(owner);
            grant_o <= '0;
            state   <= DONE;
          end else if (tmo_wrap) begin
            err_o   <= owner_mask(owner);
            grant_o <= '0;
            state   <= DONE;
          end
        end
        DONE: begin
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are plain valid qualifiers (no ready): each is meaningful only in BUSY, else forced 0.
  assign core_data_valid_o = busy && data_valid_i[owner];
  assign core_data_o       = busy ? (owner ? data1_i : data0_i) : '0;
  assign cipher_valid_o    = (busy && core_cipher_valid_i) ? owner_mask(owner) : '0;
  assign cipher_o          = (busy && core_cipher_valid_i) ? core_cipher_i : '0;

endmodule

// File: tb/tb_ascon_arbiter.sv
// Randomized scenario bench for ascon_arbiter against a job-level reference model.
module tb_ascon_arbiter;
  import ascon_pack::*;

  localparam int TMO = 8;

  logic          clock_i = 1'b0;
  logic          resetb_i;
  logic [1:0]    req_i;
  logic [127:0]  key0_i, key1_i, nonce0_i, nonce1_i;
  logic [63:0]   data0_i, data1_i;
  logic [1:0]    data_valid_i;
  logic [1:0]    grant_o, cipher_valid_o, end_o, err_o;
  logic [63:0]   cipher_o;
  logic [127:0]  tag_o;
  logic          core_start_o, core_data_valid_o;
  logic [63:0]   core_data_o;
  logic [127:0]  core_key_o, core_nonce_o;
  logic          core_cipher_valid_i, core_end_i;
  logic [63:0]   core_cipher_i;
  logic [127:0]  core_tag_i;
  arb_state_t    state_o;

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];   // tags of jobs that completed since the last reset
  logic         last_owner_m;

  always #5 clock_i = ~clock_i;

  ascon_arbiter #(.TIMEOUT_CYC(TMO)) dut (
    .clock_i             (clock_i),
    .resetb_i            (resetb_i),
    .req_i               (req_i),
    .key0_i              (key0_i),
    .key1_i              (key1_i),
    .nonce0_i            (nonce0_i),
    .nonce1_i            (nonce1_i),
    .data0_i             (data0_i),
    .data1_i             (data1_i),
    .data_valid_i        (data_valid_i),
    .grant_o             (grant_o),
    .cipher_valid_o      (cipher_valid_o),
    .cipher_o            (cipher_o),
    .end_o               (end_o),
    .err_o               (err_o),
    .tag_o               (tag_o),
    .core_start_o        (core_start_o),
    .core_data_valid_o   (core_data_valid_o),
    .core_data_o         (core_data_o),
    .core_key_o          (core_key_o),
    .core_nonce_o        (core_nonce_o),
    .core_cipher_valid_i (core_cipher_valid_i),
    .core_end_i          (core_end_i),
    .core_cipher_i       (core_cipher_i),
    .core_tag_i          (core_tag_i),
    .state_o             (state_o)
  );

  // ---------------- clock / reset helpers ----------------
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic clear_inputs();
    req_i = '0; data_valid_i = '0; data0_i = '0; data1_i = '0;
    core_cipher_valid_i = 1'b0; core_end_i = 1'b0;
    core_cipher_i = '0; core_tag_i = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    resetb_i = 1'b0;
    tick();
    tick();
    resetb_i = 1'b1;
    last_owner_m = 1'b1;
    exp_q.delete();
  endtask

  task automatic rand_keys();
    key0_i   = {$urandom(), $urandom(), $urandom(), $urandom()};
    key1_i   = {$urandom(), $urandom(), $urandom(), $urandom()};
    nonce0_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    nonce1_i = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // ---------------- reference model ----------------
  // Gather the requesters asking; one asker wins outright, otherwise the one that did not own last.
  function automatic logic model_pick(input logic [1:0] req);
    int askers[$];
    for (int k = 0; k < 2; k++) if (req[k]) askers.push_back(k);
    if (askers.size() == 1) return askers[0][0];
    foreach (askers[i]) if (askers[i][0] != last_owner_m) return askers[i][0];
    return 1'b0;
  endfunction

  function automatic logic [127:0] model_tag();
    if (exp_q.size() == 0) return '0;
    return exp_q[exp_q.size() - 1];
  endfunction

  // One full job from IDLE to IDLE. end_after = BUSY cycle carrying core_end_i (0 or >TMO: never).
  task automatic do_job(input logic [1:0] req, input int end_after, input logic [127:0] tag,
                        input bit route);
    logic         o;
    logic [1:0]   m;
    logic [127:0] ek, en, old_tag;
    logic         ev;
    logic [1:0]   ecv;
    logic [63:0]  ed, ec;
    o = model_pick(req);
    m = (o == 1'b1) ? 2'b10 : 2'b01;
    ek = o ? key1_i : key0_i;
    en = o ? nonce1_i : nonce0_i;
    old_tag = model_tag();

    req_i = req;
    tick();
    n_vec++; if (grant_o !== m) begin n_err++; $display("FAIL start_grant: got %b want %b", grant_o, m); end
    n_vec++; if (core_start_o !== 1'b1) begin n_err++; $display("FAIL start_pulse: got %b want 1", core_start_o); end
    n_vec++; if (core_key_o !== ek) begin n_err++; $display("FAIL core_key: got %h want %h", core_key_o, ek); end
    n_vec++; if (core_nonce_o !== en) begin n_err++; $display("FAIL core_nonce: got %h want %h", core_nonce_o, en); end

    // START: requests may drop, stray core strobes must not surface
    req_i = 2'($urandom_range(0, 3));
    core_end_i = 1'b1; core_cipher_valid_i = 1'b1; core_cipher_i = {$urandom(), $urandom()};
    #1;
    n_vec++; if (cipher_valid_o !== 2'b00 || cipher_o !== 64'd0) begin n_err++;
      $display("FAIL start_stray: got cv=%b c=%h want 00/0", cipher_valid_o, cipher_o); end
    tick();
    core_end_i = 1'b0;
    n_vec++; if (core_start_o !== 1'b0) begin n_err++; $display("FAIL start_len: got %b want 0", core_start_o); end
    n_vec++; if (grant_o !== m) begin n_err++; $display("FAIL busy_grant: got %b want %b", grant_o, m); end

    for (int c = 1; c <= TMO; c++) begin
      data0_i = {$urandom(), $urandom()};
      data1_i = {$urandom(), $urandom()};
      data_valid_i = 2'($urandom_range(0, 3));
      core_cipher_valid_i = 1'($urandom_range(0, 1));
      core_cipher_i = {$urandom(), $urandom()};
      if (route && c == 1) begin
        data_valid_i = 2'b01;
        core_cipher_valid_i = 1'b1;
        core_cipher_i = 64'h1122334455667788;
      end
      core_end_i = (c == end_after);
      core_tag_i = (c == end_after) ? tag : {$urandom(), $urandom(), $urandom(), $urandom()};
      ev  = data_valid_i[o];
      ed  = o ? data1_i : data0_i;
      ecv = core_cipher_valid_i ? m : 2'b00;
      ec  = core_cipher_valid_i ? core_cipher_i : 64'd0;
      #1;
      n_vec++; if (core_data_valid_o !== ev) begin n_err++; $display("FAIL data_valid: got %b want %b", core_data_valid_o, ev); end
      n_vec++; if (core_data_o !== ed) begin n_err++; $display("FAIL data: got %h want %h", core_data_o, ed); end
      n_vec++; if (cipher_valid_o !== ecv) begin n_err++; $display("FAIL cipher_valid: got %b want %b", cipher_valid_o, ecv); end
      n_vec++; if (cipher_o !== ec) begin n_err++; $display("FAIL cipher: got %h want %h", cipher_o, ec); end
      tick();
      core_end_i = 1'b0;
      if (c == end_after) begin
        exp_q.push_back(tag);
        n_vec++; if (end_o !== m || err_o !== 2'b00) begin n_err++;
          $display("FAIL end_pulse: got end=%b err=%b want end=%b err=00", end_o, err_o, m); end
        n_vec++; if (tag_o !== tag) begin n_err++; $display("FAIL tag: got %h want %h", tag_o, tag); end
        n_vec++; if (grant_o !== 2'b00) begin n_err++; $display("FAIL done_grant: got %b want 00", grant_o); end
        break;
      end else if (c == TMO) begin
        n_vec++; if (err_o !== m || end_o !== 2'b00) begin n_err++;
          $display("FAIL timeout: got err=%b end=%b want err=%b end=00", err_o, end_o, m); end
        n_vec++; if (tag_o !== old_tag) begin n_err++; $display("FAIL tag_hold: got %h want %h", tag_o, old_tag); end
        n_vec++; if (grant_o !== 2'b00) begin n_err++; $display("FAIL done_grant: got %b want 00", grant_o); end
        break;
      end else begin
        n_vec++; if (end_o !== 2'b00 || err_o !== 2'b00 || grant_o !== m) begin n_err++;
          $display("FAIL busy_hold: got end=%b err=%b grant=%b want 00/00/%b", end_o, err_o, grant_o, m); end
      end
    end

    // DONE: stray core activity, then back to IDLE
    req_i = 2'b00;
    core_end_i = 1'b1; core_cipher_valid_i = 1'b1; data_valid_i = 2'b11;
    #1;
    n_vec++; if (cipher_valid_o !== 2'b00 || core_data_valid_o !== 1'b0) begin n_err++;
      $display("FAIL done_stray: got cv=%b dv=%b want 00/0", cipher_valid_o, core_data_valid_o); end
    tick();
    clear_inputs();
    last_owner_m = o;
    n_vec++; if (end_o !== 2'b00 || err_o !== 2'b00 || grant_o !== 2'b00) begin n_err++;
      $display("FAIL idle_quiet: got end=%b err=%b grant=%b want 00", end_o, err_o, grant_o); end
    n_vec++; if (state_o !== IDLE) begin n_err++; $display("FAIL idle_state: got %0d want %0d", state_o, IDLE); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    req_i = 2'b11; core_end_i = 1'b1; core_cipher_valid_i = 1'b1;
    core_cipher_i = 64'hFFFF_FFFF_FFFF_FFFF; data_valid_i = 2'b11;
    resetb_i = 1'b0;
    tick();
    tick();
    n_vec++; if (grant_o !== 2'b00 || core_start_o !== 1'b0) begin n_err++;
      $display("FAIL rst_grant: got g=%b s=%b want 00/0", grant_o, core_start_o); end
    n_vec++; if (end_o !== 2'b00 || err_o !== 2'b00) begin n_err++;
      $display("FAIL rst_pulses: got end=%b err=%b want 00", end_o, err_o); end
    n_vec++; if (tag_o !== '0 || core_key_o !== '0 || core_nonce_o !== '0) begin n_err++;
      $display("FAIL rst_regs: got tag=%h key=%h nonce=%h want 0", tag_o, core_key_o, core_nonce_o); end
    n_vec++; if (cipher_valid_o !== 2'b00 || cipher_o !== 64'd0 || core_data_valid_o !== 1'b0 || core_data_o !== 64'd0) begin n_err++;
      $display("FAIL rst_comb: got cv=%b c=%h dv=%b d=%h want 0", cipher_valid_o, cipher_o, core_data_valid_o, core_data_o); end
    n_vec++; if (state_o !== IDLE) begin n_err++; $display("FAIL rst_state: got %0d want %0d", state_o, IDLE); end
    clear_inputs();
    resetb_i = 1'b1;
    last_owner_m = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_single_job();
    rand_keys();
    key0_i = 128'h000102030405060708090A0B0C0D0E0F;
    do_job(2'b01, 3, {16{8'hAB}}, 1'b0);
  endtask

  task automatic test_tie();
    reset_dut();
    for (int j = 0; j < 3; j++) begin
      rand_keys();
      do_job(2'b11, int'($urandom_range(1, TMO - 1)), {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
    end
  endtask

  task automatic test_routing();
    rand_keys();
    do_job(2'b10, 4, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
  endtask

  task automatic test_timeout();
    rand_keys();
    do_job(2'b01, 0, '0, 1'b0);
    rand_keys();
    do_job(2'b10, TMO, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
  endtask

  task automatic test_reset_mid_busy();
    rand_keys();
    req_i = 2'b01;
    tick();
    req_i = 2'b00;
    tick();
    tick();
    data_valid_i = 2'b11; core_cipher_valid_i = 1'b1; core_cipher_i = {$urandom(), $urandom()};
    #1;
    resetb_i = 1'b0;
    #1;
    n_vec++; if (grant_o !== 2'b00 || core_key_o !== '0 || core_nonce_o !== '0 || tag_o !== '0) begin n_err++;
      $display("FAIL midrst_regs: got g=%b key=%h nonce=%h tag=%h want 0", grant_o, core_key_o, core_nonce_o, tag_o); end
    n_vec++; if (core_data_valid_o !== 1'b0 || cipher_valid_o !== 2'b00 || cipher_o !== 64'd0 || core_data_o !== 64'd0) begin n_err++;
      $display("FAIL midrst_comb: got dv=%b cv=%b c=%h d=%h want 0", core_data_valid_o, cipher_valid_o, cipher_o, core_data_o); end
    tick();
    n_vec++; if (end_o !== 2'b00 || err_o !== 2'b00) begin n_err++;
      $display("FAIL midrst_pulse: got end=%b err=%b want 00", end_o, err_o); end
    clear_inputs();
    resetb_i = 1'b1;
    last_owner_m = 1'b1;
    exp_q.delete();
    rand_keys();
    do_job(2'b10, 2, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
  endtask

  task automatic test_stray_end();
    logic [127:0] t;
    t = model_tag();
    core_end_i = 1'b1; core_cipher_valid_i = 1'b1;
    core_tag_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    #1;
    n_vec++; if (cipher_valid_o !== 2'b00 || cipher_o !== 64'd0) begin n_err++;
      $display("FAIL idle_stray_cv: got cv=%b c=%h want 00/0", cipher_valid_o, cipher_o); end
    tick();
    n_vec++; if (end_o !== 2'b00 || tag_o !== t || grant_o !== 2'b00) begin n_err++;
      $display("FAIL idle_stray_end: got end=%b tag=%h g=%b want 00/%h/00", end_o, tag_o, grant_o, t); end
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 12; j++) begin
      int ea;
      rand_keys();
      ea = int'($urandom_range(0, TMO + 2));
      do_job(2'($urandom_range(1, 3)), ea, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
    end
  endtask

  initial begin
    clear_inputs();
    rand_keys();
    resetb_i = 1'b1;
    last_owner_m = 1'b1;
    #2;
    test_reset();
    test_single_job();
    test_tie();
    test_routing();
    test_timeout();
    test_reset_mid_busy();
    test_stray_end();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
